// File: rtl/hg_sample_ctrl.sv
// Mercury tilt-switch sampler: synchronises the raw contact code, qualifies it
// over several divided sample ticks and hands accepted codes off via valid/ack.
module hg_sample_ctrl #(
  parameter int CLK_DIV    = 50000,
  parameter int STABLE_CNT = 4,
  parameter int HOLDOFF    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] hg_raw,
  output logic [3:0] hg_q,
  output logic       upd_valid,
  input  logic       upd_ack,
  output logic       busy,
  output logic [7:0] chg_cnt
);

  localparam int DIV_W   = $clog2(CLK_DIV);
  localparam int MATCH_W = $clog2(STABLE_CNT + 1);
  localparam int HOLD_W  = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;

  localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(CLK_DIV - 1);
  localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(STABLE_CNT - 1);
  localparam logic [HOLD_W-1:0]  HOLD_INIT  = HOLD_W'(HOLDOFF);

  typedef enum logic [1:0] {IDLE, QUAL, PEND, HOLD} state_t;

  state_t             state;
  logic [3:0]         sync_1;
  logic [3:0]         hg_s;
  logic [DIV_W-1:0]   div_cnt;
  logic               tick;
  logic [3:0]         cand;
  logic [MATCH_W-1:0] match;
  logic [HOLD_W-1:0]  hold;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_1 <= '0;
      hg_s   <= '0;
    end else begin
      sync_1 <= hg_raw;
      hg_s   <= sync_1;
    end
  end

  assign tick = (div_cnt == DIV_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) div_cnt <= '0;
    else     div_cnt <= tick ? '0 : div_cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      hg_q      <= '0;
      upd_valid <= 1'b0;
      busy      <= 1'b0;
      chg_cnt   <= '0;
      cand      <= '0;
      match     <= '0;
      hold      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (tick && (hg_s != hg_q)) begin
            cand  <= hg_s;
            match <= MATCH_W'(1);
            busy  <= 1'b1;
            if (STABLE_CNT == 1) begin
              hg_q      <= hg_s;
              upd_valid <= 1'b1;
              state     <= PEND;
            end else begin
              state <= QUAL;
            end
          end
        end
        QUAL: begin
          if (tick) begin
            if (hg_s == cand) begin
              match <= match + 1'b1;
              if (match == MATCH_LAST) begin
                hg_q      <= cand;
                upd_valid <= 1'b1;
                state     <= PEND;
              end
            end else if (hg_s == hg_q) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              cand  <= hg_s;
              match <= MATCH_W'(1);
            end
          end
        end
        PEND: begin
          // Ticks are deliberately ignored here, so a tick on the ack edge is lost.
          if (upd_ack) begin
            upd_valid <= 1'b0;
            if (chg_cnt != 8'hFF) chg_cnt <= chg_cnt + 1'b1;
            if (HOLDOFF == 0) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state <= HOLD;
              hold  <= HOLD_INIT;
            end
          end
        end
        HOLD: begin
          if (tick) begin
            hold <= hold - 1'b1;
            if (hold <= HOLD_W'(1)) begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hg_sample_ctrl.sv
// Directed bench for hg_sample_ctrl with CLK_DIV=4, STABLE_CNT=3, HOLDOFF=2.
// Edge numbers e count rising edges since reset release; ticks land on e = 4, 8, 12, ...
`timescale 1ns/1ps
module tb_hg_sample_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] hg_raw = 4'b0000;
  logic       upd_ack = 1'b0;
  logic [3:0] hg_q;
  logic       upd_valid;
  logic       busy;
  logic [7:0] chg_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  int e = 0;
  int v_hi = 0;
  int q_bad = 0;

  hg_sample_ctrl #(.CLK_DIV(4), .STABLE_CNT(3), .HOLDOFF(2)) dut (
    .clk(clk), .rst(rst), .hg_raw(hg_raw), .hg_q(hg_q), .upd_valid(upd_valid),
    .upd_ack(upd_ack), .busy(busy), .chg_cnt(chg_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    e++;
    if (upd_valid) v_hi++;
    if (hg_q == 4'b0011) q_bad++;
  endtask

  task automatic step_to(input int t);
    while (e < t) step();
  endtask

  // Asynchronous reset mid-cycle, outputs checked before any clock edge.
  task automatic reset_dut(input logic [3:0] raw);
    @(posedge clk);
    #3;
    upd_ack = 1'b0;
    hg_raw  = raw;
    rst     = 1'b1;
    #1;
    check_val("rst_hg_q", hg_q, 4'b0000);
    check_val("rst_valid", upd_valid, 1'b0);
    check_val("rst_busy", busy, 1'b0);
    check_val("rst_chg_cnt", chg_cnt, 8'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst  = 1'b0;
    e    = 0;
    v_hi = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int bad;
    int to_cnt;
    int wait_k;
    logic [3:0] tgt;

    reset_dut(4'b0000);

    // Clean change with ack tied high
    hg_raw  = 4'b0110;
    upd_ack = 1'b1;
    step_to(11);
    check_val("clean_pre_valid", upd_valid, 1'b0);
    check_val("clean_qual_busy", busy, 1'b1);
    step_to(12);
    check_val("clean_valid", upd_valid, 1'b1);
    check_val("clean_hg_q", hg_q, 4'b0110);
    check_val("clean_cnt_pre", chg_cnt, 8'd0);
    step_to(13);
    check_val("clean_valid_drop", upd_valid, 1'b0);
    check_val("clean_cnt", chg_cnt, 8'd1);
    step_to(19);
    check_val("clean_hold_busy", busy, 1'b1);
    step_to(20);
    check_val("clean_idle", busy, 1'b0);
    check_val("clean_pulse_len", v_hi, 1);
    upd_ack = 1'b0;

    // Reset mid-QUAL with raw held at 1111
    hg_raw = 4'b1111;
    step_to(29);
    check_val("midrst_in_qual", busy, 1'b1);
    reset_dut(4'b1111);
    step_to(11);
    check_val("midrst_no_early", v_hi, 0);
    step_to(12);
    check_val("midrst_valid", upd_valid, 1'b1);
    check_val("midrst_hg_q", hg_q, 4'b1111);
    upd_ack = 1'b1;
    step_to(13);
    check_val("midrst_cnt", chg_cnt, 8'd1);
    upd_ack = 1'b0;
    step_to(20);
    check_val("midrst_idle", busy, 1'b0);

    // Glitch: 1100 for two ticks then back to 0000
    reset_dut(4'b0000);
    hg_raw = 4'b1100;
    step_to(8);
    hg_raw = 4'b0000;
    step_to(11);
    check_val("glitch_qual", busy, 1'b1);
    step_to(12);
    check_val("glitch_idle", busy, 1'b0);
    step_to(24);
    check_val("glitch_no_valid", v_hi, 0);
    check_val("glitch_hg_q", hg_q, 4'b0000);
    check_val("glitch_cnt", chg_cnt, 8'd0);

    // Candidate switch 0011 -> 1001
    hg_raw = 4'b0011;
    q_bad  = 0;
    v_hi   = 0;
    step_to(32);
    hg_raw = 4'b1001;
    step_to(43);
    check_val("cand_pre_valid", upd_valid, 1'b0);
    step_to(44);
    check_val("cand_valid", upd_valid, 1'b1);
    check_val("cand_hg_q", hg_q, 4'b1001);
    check_val("cand_never_0011", q_bad, 0);
    upd_ack = 1'b1;
    step_to(45);
    check_val("cand_cnt", chg_cnt, 8'd1);
    upd_ack = 1'b0;
    step_to(52);
    check_val("cand_idle", busy, 1'b0);

    // Back-pressure then hold-off
    hg_raw = 4'b1111;
    step_to(64);
    check_val("bp_valid", upd_valid, 1'b1);
    check_val("bp_hg_q", hg_q, 4'b1111);
    hg_raw = 4'b0000;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (!upd_valid || hg_q != 4'b1111) bad++;
    end
    check_val("bp_stable_cycles_bad", bad, 0);
    upd_ack = 1'b1;
    step_to(85);
    check_val("bp_valid_drop", upd_valid, 1'b0);
    check_val("bp_cnt", chg_cnt, 8'd2);
    check_val("bp_hold_busy", busy, 1'b1);
    upd_ack = 1'b0;
    step_to(91);
    check_val("bp_hold_busy_late", busy, 1'b1);
    step_to(92);
    check_val("bp_hold_done", busy, 1'b0);
    step_to(103);
    check_val("bp_requal_pre", upd_valid, 1'b0);
    step_to(104);
    check_val("bp_requal_valid", upd_valid, 1'b1);
    check_val("bp_requal_hg_q", hg_q, 4'b0000);
    upd_ack = 1'b1;
    step_to(105);
    check_val("bp_requal_cnt", chg_cnt, 8'd3);
    upd_ack = 1'b0;

    // Saturation over 260 acknowledged updates
    reset_dut(4'b0000);
    upd_ack = 1'b1;
    to_cnt = 0;
    for (int i = 0; i < 260; i++) begin
      tgt = i[0] ? 4'b0101 : 4'b1010;
      hg_raw = tgt;
      wait_k = 0;
      while (hg_q != tgt && wait_k < 80) begin
        step();
        wait_k++;
      end
      if (hg_q != tgt) to_cnt++;
      wait_k = 0;
      while (busy && wait_k < 80) begin
        step();
        wait_k++;
      end
      if (busy) to_cnt++;
      if (i == 253) check_val("sat_cnt_254", chg_cnt, 8'd254);
      if (i == 254) check_val("sat_cnt_255", chg_cnt, 8'd255);
    end
    check_val("sat_cnt_final", chg_cnt, 8'd255);
    check_val("sat_timeouts", to_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
